// File: rtl/gpmc_host_master.sv
`timescale 1ns/1ps
// Purpose: GPMC-style bus initiator issuing single async read/write cycles (10b addr, 16b data).
// Latency: accept-to-ready = 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (reads add TURN_CYC); rsp_valid at HOLD entry.
// Backpressure: cmd_ready is high only in IDLE; requester holds cmd_valid until accepted.
//
// Ports:
//   clk, rst                      clock (rising edge) and async active-high reset
//   cmd_valid/cmd_ready           request handshake; cmd_wr, cmd_addr, cmd_wdata latched on accept
//   rsp_valid, rsp_wr, rsp_rdata  one-cycle completion pulse, transaction type, captured read data
//   busy                          high whenever the FSM is not in IDLE
//   gpmc_a, gpmc_d_o, gpmc_d_oe   bus address, write data and its tristate enable
//   gpmc_d_i                      bus read data
//   gpmc_nwe, gpmc_nre            active-low write/read strobes
module gpmc_host_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int TURN_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [9:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [9:0]  gpmc_a,
    output logic [15:0] gpmc_d_o,
    output logic        gpmc_d_oe,
    input  logic [15:0] gpmc_d_i,
    output logic        gpmc_nwe,
    output logic        gpmc_nre
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        TURN   = 3'd4
    } state_t;

    // Phase counter load values: each phase runs until the counter reaches zero.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_LD   = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       wr_q;
    logic       accept;
    logic       strobe_done;

    // cmd_ready is a registered copy of "state is IDLE", so the handshake never
    // sees a combinational path from cmd_valid to any output.
    assign accept      = cmd_valid && cmd_ready;
    assign strobe_done = (state == STROBE) && (state_nxt == HOLD);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    // Writes never need a turnaround: the host owns the bus.
                    if (wr_q || (TURN_CYC == 0)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = TURN;
                        cnt_nxt   = TURN_LD;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            TURN: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // All outputs are registered from the next state so pin timing lines up
    // exactly with the state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= 16'h0000;
            gpmc_a    <= 10'h000;
            gpmc_d_o  <= 16'h0000;
            gpmc_d_oe <= 1'b0;
            gpmc_nwe  <= 1'b1;
            gpmc_nre  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cmd_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);

            if (accept) begin
                wr_q     <= cmd_wr;
                gpmc_a   <= cmd_addr;
                gpmc_d_o <= cmd_wdata;
            end

            // Data drive only for writes; released on the edge back to IDLE.
            if (accept) begin
                gpmc_d_oe <= cmd_wr;
            end else if ((state_nxt == IDLE) || (state_nxt == TURN)) begin
                gpmc_d_oe <= 1'b0;
            end

            // STROBE is only reachable through SETUP, so wr_q is already valid.
            gpmc_nwe <= !((state_nxt == STROBE) && wr_q);
            gpmc_nre <= !((state_nxt == STROBE) && !wr_q);

            // Read data sampled on the same edge the strobe rises.
            rsp_valid <= strobe_done;
            if (strobe_done) begin
                rsp_wr <= wr_q;
                if (!wr_q) begin
                    rsp_rdata <= gpmc_d_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpmc_host_master.sv
`timescale 1ns/1ps
// Directed bench for gpmc_host_master: default timing plus a fast (1/1/1/0)
// and a slow (15/15/15/15) instance sharing the command and read-data inputs.
module tb_gpmc_host_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [9:0]  cmd_addr = 10'h000;
    logic [15:0] cmd_wdata = 16'h0000;
    logic [15:0] d_in = 16'h0000;

    logic        cmd_ready, rsp_valid, rsp_wr, busy, gpmc_d_oe, gpmc_nwe, gpmc_nre;
    logic [15:0] rsp_rdata, gpmc_d_o;
    logic [9:0]  gpmc_a;

    logic        s_cmd_ready, s_rsp_valid, s_rsp_wr, s_busy, s_d_oe, s_nwe, s_nre;
    logic [15:0] s_rsp_rdata, s_d_o;
    logic [9:0]  s_a;

    logic        b_cmd_ready, b_rsp_valid, b_rsp_wr, b_busy, b_d_oe, b_nwe, b_nre;
    logic [15:0] b_rsp_rdata, b_d_o;
    logic [9:0]  b_a;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gpmc_host_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .busy(busy),
        .gpmc_a(gpmc_a), .gpmc_d_o(gpmc_d_o), .gpmc_d_oe(gpmc_d_oe), .gpmc_d_i(d_in),
        .gpmc_nwe(gpmc_nwe), .gpmc_nre(gpmc_nre)
    );

    gpmc_host_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(0)) dut_s (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(s_rsp_valid), .rsp_wr(s_rsp_wr), .rsp_rdata(s_rsp_rdata), .busy(s_busy),
        .gpmc_a(s_a), .gpmc_d_o(s_d_o), .gpmc_d_oe(s_d_oe), .gpmc_d_i(d_in),
        .gpmc_nwe(s_nwe), .gpmc_nre(s_nre)
    );

    gpmc_host_master #(.SETUP_CYC(15), .STROBE_CYC(15), .HOLD_CYC(15), .TURN_CYC(15)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_wr(b_rsp_wr), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
        .gpmc_a(b_a), .gpmc_d_o(b_d_o), .gpmc_d_oe(b_d_oe), .gpmc_d_i(d_in),
        .gpmc_nwe(b_nwe), .gpmc_nre(b_nre)
    );

    // Bus-level invariants on every instance, every cycle.
    always @(negedge clk) begin
        if ((!gpmc_nwe && !gpmc_nre) || (!s_nwe && !s_nre) || (!b_nwe && !b_nre)) begin
            fails++;
            $display("FAIL strobe_overlap t=%0t: nwe/nre low together, required never", $time);
        end
        if ((!gpmc_nre && gpmc_d_oe) || (!s_nre && s_d_oe) || (!b_nre && b_d_oe)) begin
            fails++;
            $display("FAIL oe_during_read t=%0t: d_oe=1 with nre low, required 0", $time);
        end
    end

    // Wait until every instance is idle, then present one command for one cycle.
    task automatic launch(input logic wr, input logic [9:0] addr, input logic [15:0] wd);
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (cmd_ready && s_cmd_ready && b_cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL launch_timeout: ready=%b%b%b required 111", cmd_ready, s_cmd_ready, b_cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({cmd_ready, rsp_valid, rsp_wr, busy, gpmc_d_oe, gpmc_nwe, gpmc_nre} !== 7'b0000011) begin
            fails++;
            $display("FAIL reset_ctrl: rdy/rsp/wr/busy/oe/nwe/nre=%b required 0000011",
                     {cmd_ready, rsp_valid, rsp_wr, busy, gpmc_d_oe, gpmc_nwe, gpmc_nre});
        end
        tests++;
        if ({gpmc_a, gpmc_d_o, rsp_rdata} !== 42'h0) begin
            fails++;
            $display("FAIL reset_data: a=%h d_o=%h rdata=%h required 0", gpmc_a, gpmc_d_o, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({cmd_ready, busy} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: rdy/busy=%b required 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write();
        logic bz, nwe_e;
        launch(1'b1, 10'h172, 16'hA5A5);
        for (int i = 1; i <= 9; i++) begin
            bz    = (i <= 8);
            nwe_e = !(i >= 3 && i <= 6);
            tests++;
            if ({busy, cmd_ready, gpmc_d_oe, gpmc_nwe, gpmc_nre, rsp_valid} !==
                {bz, !bz, bz, nwe_e, 1'b1, (i == 7)}) begin
                fails++;
                $display("FAIL write_ctrl cyc %0d: busy/rdy/oe/nwe/nre/rsp=%b required %b", i,
                         {busy, cmd_ready, gpmc_d_oe, gpmc_nwe, gpmc_nre, rsp_valid},
                         {bz, !bz, bz, nwe_e, 1'b1, (i == 7)});
            end
            if (i <= 8) begin
                tests++;
                if (gpmc_a !== 10'h172 || gpmc_d_o !== 16'hA5A5) begin
                    fails++;
                    $display("FAIL write_bus cyc %0d: a=%h d=%h required 172 a5a5", i, gpmc_a, gpmc_d_o);
                end
            end
            if (i == 7) begin
                tests++;
                if (rsp_wr !== 1'b1) begin
                    fails++;
                    $display("FAIL write_rsp_wr: %b required 1", rsp_wr);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_read();
        logic bz, nre_e;
        launch(1'b0, 10'h304, 16'hFFFF);
        for (int i = 1; i <= 10; i++) begin
            bz    = (i <= 9);
            nre_e = !(i >= 3 && i <= 6);
            tests++;
            if ({busy, cmd_ready, gpmc_d_oe, gpmc_nwe, gpmc_nre, rsp_valid} !==
                {bz, !bz, 1'b0, 1'b1, nre_e, (i == 7)}) begin
                fails++;
                $display("FAIL read_ctrl cyc %0d: busy/rdy/oe/nwe/nre/rsp=%b required %b", i,
                         {busy, cmd_ready, gpmc_d_oe, gpmc_nwe, gpmc_nre, rsp_valid},
                         {bz, !bz, 1'b0, 1'b1, nre_e, (i == 7)});
            end
            if (i == 7) begin
                tests++;
                if (rsp_rdata !== 16'h1114 || rsp_wr !== 1'b0 || gpmc_a !== 10'h304) begin
                    fails++;
                    $display("FAIL read_rsp: rdata=%h wr=%b a=%h required 1114 0 304", rsp_rdata, rsp_wr, gpmc_a);
                end
            end
            // Responder model: drives data only while nre is low.
            d_in = gpmc_nre ? 16'h0000 : 16'h1114;
            @(negedge clk);
        end
        d_in = 16'h0000;
    endtask

    task automatic test_capture();
        d_in = 16'h0000;
        launch(1'b0, 10'h055, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) begin
                tests++;
                if (gpmc_nre !== 1'b0) begin
                    fails++;
                    $display("FAIL capture_last_strobe: nre=%b required 0", gpmc_nre);
                end
            end
            if (i == 7 || i == 8) begin
                tests++;
                if (rsp_rdata !== 16'hBEEF) begin
                    fails++;
                    $display("FAIL capture_cyc%0d: rdata=%h required beef", i, rsp_rdata);
                end
            end
            if (i == 6) d_in = 16'hBEEF;
            if (i == 7) d_in = 16'h1234;
            @(negedge clk);
        end
        d_in = 16'h0000;
    endtask

    task automatic test_back_to_back();
        int first_rdy = 0, oe_rise = 0, nre_rise = 0, gap = 0, pulses = 0;
        logic prev_nre = 1'b1;
        launch(1'b0, 10'h000, 16'h0000);  // settle: all idle before the real pair
        for (int n = 0; n < 70 && !(cmd_ready && s_cmd_ready && b_cmd_ready); n++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 10'h3FE;
        @(negedge clk);
        cmd_wr    = 1'b1;
        cmd_addr  = 10'h004;
        cmd_wdata = 16'h0001;
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) cmd_valid = 1'b0;
            if (rsp_valid) pulses++;
            if (cmd_ready && first_rdy == 0) first_rdy = i;
            if (gpmc_d_oe && oe_rise == 0) oe_rise = i;
            if (nre_rise == 0 && gpmc_nre && !prev_nre) nre_rise = i;
            prev_nre = gpmc_nre;
            if (nre_rise != 0 && oe_rise == 0 && !gpmc_d_oe && gpmc_nre && gpmc_nwe) gap++;
            if (i == 11) begin
                tests++;
                if (gpmc_a !== 10'h004 || gpmc_d_o !== 16'h0001) begin
                    fails++;
                    $display("FAIL b2b_write_bus: a=%h d=%h required 004 0001", gpmc_a, gpmc_d_o);
                end
            end
            @(negedge clk);
        end
        tests++;
        if (first_rdy != 10 || oe_rise != 11 || nre_rise != 7) begin
            fails++;
            $display("FAIL b2b_timing: ready@%0d oe@%0d nre_rise@%0d required 10 11 7", first_rdy, oe_rise, nre_rise);
        end
        tests++;
        if (gap != 4) begin
            fails++;
            $display("FAIL b2b_turn_gap: %0d idle cycles required 4", gap);
        end
        tests++;
        if (pulses != 2 || rsp_wr !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rsp: pulses=%0d last_wr=%b required 2 1", pulses, rsp_wr);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        launch(1'b1, 10'h0AA, 16'h3C3C);
        for (int i = 1; i < 4; i++) @(negedge clk);
        tests++;
        if (gpmc_nwe !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_pre: nwe=%b required 0", gpmc_nwe);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({gpmc_nwe, gpmc_nre, gpmc_d_oe, busy} !== 4'b1100) begin
            fails++;
            $display("FAIL rstmid_async: nwe/nre/oe/busy=%b required 1100", {gpmc_nwe, gpmc_nre, gpmc_d_oe, busy});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL rstmid_no_rsp: pulses=%0d required 0", pulses);
        end
        launch(1'b0, 10'h123, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            if (rsp_valid) pulses++;
            if (i == 7) begin
                tests++;
                if (rsp_rdata !== 16'h5A5A || rsp_wr !== 1'b0) begin
                    fails++;
                    $display("FAIL rstmid_read: rdata=%h wr=%b required 5a5a 0", rsp_rdata, rsp_wr);
                end
            end
            d_in = gpmc_nre ? 16'h0000 : 16'h5A5A;
            @(negedge clk);
        end
        d_in = 16'h0000;
        tests++;
        if (pulses != 1 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_read_done: pulses=%0d rdy=%b required 1 1", pulses, cmd_ready);
        end
    endtask

    task automatic test_sweep();
        int s_low, s_per, b_low, b_per, b_exp;
        for (int w = 1; w >= 0; w--) begin
            s_low = 0; s_per = 0; b_low = 0; b_per = 0;
            b_exp = (w == 1) ? 46 : 61;
            launch(w[0], 10'h2AA, 16'h5555);
            for (int i = 1; i <= 70; i++) begin
                if (!(w == 1 ? s_nwe : s_nre)) s_low++;
                if (!(w == 1 ? b_nwe : b_nre)) b_low++;
                if (s_cmd_ready && s_per == 0) s_per = i;
                if (b_cmd_ready && b_per == 0) b_per = i;
                @(negedge clk);
            end
            tests++;
            if (s_low != 1 || s_per != 4) begin
                fails++;
                $display("FAIL sweep_fast wr=%0d: strobe=%0d period=%0d required 1 4", w, s_low, s_per);
            end
            tests++;
            if (b_low != 15 || b_per != b_exp) begin
                fails++;
                $display("FAIL sweep_slow wr=%0d: strobe=%0d period=%0d required 15 %0d", w, b_low, b_per, b_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_capture();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gpmc_host_master.md
Name: gpmc_host_master

Overview:
- Synchronous GPMC bus initiator: issues single asynchronous read/write cycles on a 10-bit address / 16-bit data GPMC-style bus with active-low nwe/nre strobes.
- It is the host end of the same bus the FPGA command register file answers as a responder.
- Used for on-board self-test and loopback, in a second FPGA or a bench harness, and for driving the command/status register map without the ARM.
- Timing is set per phase (setup/strobe/hold/turnaround) in clk cycles.

Parameters:
- SETUP_CYC, 2: cycles address/data are stable before the strobe falls; legal range 1..15.
- STROBE_CYC, 4: cycles nwe or nre is held low; legal range 1..15.
- HOLD_CYC, 2: cycles address/data are held after the strobe rises; legal range 1..15.
- TURN_CYC, 1: idle cycles with the data bus released after a read; legal range 0..15, where 0 skips the TURN state.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  transaction request.
- cmd_ready  out  1  high only in IDLE; a transfer occurs when cmd_valid and cmd_ready are both high.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  10  target address.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse for both reads and writes.
- rsp_wr  out  1  type of the completed transaction.
- rsp_rdata  out  16  captured read data; unchanged after a write.
- busy  out  1  high whenever the state is not IDLE.
- gpmc_a  out  10  bus address.
- gpmc_d_o  out  16  bus write data.
- gpmc_d_oe  out  1  tristate enable for gpmc_d_o; the top level builds the IOBUF.
- gpmc_d_i  in  16  bus read data.
- gpmc_nwe  out  1  write strobe, active low.
- gpmc_nre  out  1  read strobe, active low.

Behaviour:
Reset values:
- cmd_ready=0 while rst is high, then 1 (IDLE).
- rsp_valid=0, rsp_wr=0, rsp_rdata=0, busy=0.
- gpmc_a=0, gpmc_d_o=0, gpmc_d_oe=0, gpmc_nwe=1, gpmc_nre=1.
- All outputs are registered; no combinational path from inputs to bus pins.

FSM states: IDLE, SETUP, STROBE, HOLD, TURN. A 4-bit phase counter is loaded on entry to each state.
- IDLE:
  - On handshake at edge k, latch addr, wr and wdata, and go to SETUP.
  - gpmc_a and gpmc_d_o update at edge k.
  - For a write, gpmc_d_oe rises at edge k; for a read it stays 0.
- SETUP: lasts SETUP_CYC cycles with both strobes high, then STROBE.
- STROBE:
  - The strobe (nwe for a write, nre for a read) falls at the entry edge and stays low exactly STROBE_CYC cycles.
  - Read capture: rsp_rdata <= gpmc_d_i on the edge that leaves STROBE, which is the same edge the strobe rises.
- HOLD:
  - Lasts HOLD_CYC cycles; address and write data are held, gpmc_d_oe stays as in SETUP.
  - rsp_valid pulses on the entry edge and stays high for exactly one cycle, with rsp_wr = latched wr.
- After HOLD:
  - Write: go to IDLE; gpmc_d_oe falls on that edge.
  - Read with TURN_CYC > 0: go to TURN for TURN_CYC cycles, then IDLE.
  - Read with TURN_CYC = 0: go directly to IDLE.
- gpmc_a keeps the last address in IDLE; there is no bus parking.

Transaction timing:
- Accept-to-ready period: write = 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; read adds TURN_CYC.
- Defaults: write 9 cycles, read 10 cycles.
- There is at least one IDLE cycle between transactions.

Boundary conditions:
- cmd_valid while busy: not accepted; the requester must hold it. Inputs are ignored outside IDLE, so a cmd_* change mid-transaction has no effect.
- Reset at any point (including with a strobe low): strobes go high and gpmc_d_oe goes 0 immediately (asynchronous); no rsp_valid is issued for the aborted transaction; the FSM restarts in IDLE.
- nwe and nre are never low together, and neither is low while in IDLE, SETUP, HOLD or TURN.
- gpmc_d_oe is never 1 during any read phase.

Test Plan:
- Write: defaults, write addr 0x172 data 0xA5A5 -> busy for 8 cycles after accept; gpmc_a = 0x172 and gpmc_d_oe=1 for 8 cycles; nwe low exactly cycles 3..6; one rsp_valid with rsp_wr=1; nre stays 1.
- Read: read 0x304 with the responder model driving 0x1114 while nre is low -> nre low 4 cycles; rsp_rdata=0x1114 with a single rsp_valid pulse and rsp_wr=0; gpmc_d_oe=0 throughout; cmd_ready returns 10 cycles after accept.
- Capture point: the model changes gpmc_d_i from 0x0000 to 0xBEEF in the last strobe cycle -> rsp_rdata=0xBEEF. A change to 0x1234 on the cycle after the strobe rises is not captured.
- Back-to-back with turnaround: cmd_valid held high with read 0x3FE then write 0x004 data 0x0001 -> the write is accepted only after TURN; at least 2 cycles with gpmc_d_oe=0 and both strobes high between nre rising and the write's data drive; two rsp_valid pulses.
- Reset mid-strobe: rst asserted in the 2nd nwe-low cycle -> nwe=1 and gpmc_d_oe=0 in the same cycle; no rsp_valid; after release a new read completes correctly.
- Parameter sweep: SETUP/STROBE/HOLD/TURN = 1/1/1/0, then 15/15/15/15 -> strobe widths and periods match the formulas (4 and 4 cycles; 46 and 61 cycles) and no overlap assertions fire.
